// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe, sync, blanking, draw/fetch
// coordinates, line/frame pulses and a frame counter. Drop-in successor to vga_controller.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int LOOKAHEAD = 2,
  parameter int CW        = 10
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          en,
  output logic          pixel_clk,
  output logic          pix_ce,
  output logic          hs,
  output logic          vs,
  output logic          blank_n,
  output logic          sync_n,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic [CW-1:0] FetchX,
  output logic [CW-1:0] FetchY,
  output logic          fetch_valid,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [DW:0]   DIV_HALF = (DW+1)'(CLK_DIV / 2);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW:0]   H_TOT_W  = (CW+1)'(H_TOTAL);
  localparam logic [CW:0]   H_ACT_W  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   V_ACT_W  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   HS_LO    = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_HI    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   VS_LO    = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_HI    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0]   LA_W     = (CW+1)'(LOOKAHEAD);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end
  if (LOOKAHEAD < 0 || LOOKAHEAD >= H_TOTAL) begin : g_bad_lookahead
    $error("vga_timing_gen: LOOKAHEAD must be in 0..H_TOTAL-1");
  end
  if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  logic [DW-1:0] div, div_nx;
  logic [CW-1:0] hc, vc, hc_nx, vc_nx, fx_nx, fy_nx;
  logic [CW:0]   fsum;
  logic          hs_on, vs_on, vis_nx, fvis_nx, at_origin;

  function automatic logic in_window(input logic [CW-1:0] v, input logic [CW:0] lo,
                                     input logic [CW:0] hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
  endfunction

  assign pix_ce = en && (div == DIV_LAST);
  assign sync_n = 1'b0;

  always_comb begin
    div_nx = div;
    hc_nx  = hc;
    vc_nx  = vc;
    if (pix_ce) begin
      div_nx = '0;
      if (hc == H_LAST) begin
        hc_nx = '0;
        vc_nx = (vc == V_LAST) ? '0 : vc + ONE;
      end else begin
        hc_nx = hc + ONE;
      end
    end else if (en) begin
      div_nx = div + DIV_ONE;
    end

    // Lookahead never exceeds one line, so at most one wrap into the next line.
    fsum  = {1'b0, hc_nx} + LA_W;
    fx_nx = fsum[CW-1:0];
    fy_nx = vc_nx;
    if (fsum >= H_TOT_W) begin
      fx_nx = CW'(fsum - H_TOT_W);
      fy_nx = (vc_nx == V_LAST) ? '0 : vc_nx + ONE;
    end

    hs_on     = in_window(hc_nx, HS_LO, HS_HI);
    vs_on     = in_window(vc_nx, VS_LO, VS_HI);
    vis_nx    = ({1'b0, hc_nx} < H_ACT_W) && ({1'b0, vc_nx} < V_ACT_W);
    fvis_nx   = ({1'b0, fx_nx} < H_ACT_W) && ({1'b0, fy_nx} < V_ACT_W);
    at_origin = (hc_nx == '0) && (vc_nx == '0);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div         <= '0;
      hc          <= H_LAST;
      vc          <= V_LAST;
      pixel_clk   <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      FetchX      <= '0;
      FetchY      <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      blank_n     <= 1'b0;
      fetch_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      if (en) begin
        div       <= div_nx;
        pixel_clk <= ({1'b0, div_nx} >= DIV_HALF);
      end
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hc          <= hc_nx;
        vc          <= vc_nx;
        DrawX       <= hc_nx;
        DrawY       <= vc_nx;
        FetchX      <= fx_nx;
        FetchY      <= fy_nx;
        hs          <= hs_on ? HS_POL : ~HS_POL;
        vs          <= vs_on ? VS_POL : ~VS_POL;
        blank_n     <= vis_nx;
        fetch_valid <= fvis_nx;
        line_start  <= (hc_nx == '0);
        frame_start <= at_origin;
        if (at_origin) frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
